mux_func_sweeper: RTL and testbench

Exhaustive stimulus-and-check stage that sits directly upstream of the 5-input mux-based logic function (inputs a, b, c, d, e; output y). After a start pulse, it drives all 32 input combinations in order and waits a programmable settle time on each. It then samples y, compares it against a golden truth table, and reports a pass/fail summary. It is used on the lab board and in simulation to prove the gate-level function without manual toggling.

---
 rtl/mux_func_sweeper_if.sv | 26 ++
 rtl/mux_func_sweeper.sv | 118 +++++++++++
 tb/tb_mux_func_sweeper.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mux_func_sweeper_if.sv
// Stimulus/check bus between the sweeper and the 5-input function under test.
// master = sweeper side, slave = function-under-test / observer side.
interface mux_func_sweeper_if;
    logic       start;
    logic       y;
    logic       a;
    logic       b;
    logic       c;
    logic       d;
    logic       e;
    logic       busy;
    logic       done;
    logic       pass;
    logic [5:0] err_count;
    logic [4:0] first_fail;

    modport master (
        input  start, y,
        output a, b, c, d, e, busy, done, pass, err_count, first_fail
    );

    modport slave (
        output start, y,
        input  a, b, c, d, e, busy, done, pass, err_count, first_fail
    );
endinterface

// File: rtl/mux_func_sweeper.sv
// Exhaustive 32-vector sweeper that checks a 5-input function against a golden truth table.
// Optional MUX_SWEEP_STOP_ON_FAIL_EN ends the sweep on the first mismatching vector.
module mux_func_sweeper #(
    parameter int          SETTLE = 2,
    parameter logic [31:0] EXPECT = 32'hB31E114C
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_func_sweeper_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_vec;
    logic [4:0] w_vec_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [5:0] r_err;
    logic [5:0] w_err_nxt;
    logic [4:0] r_ff;
    logic [4:0] w_ff_nxt;
    logic       w_mismatch;
    logic       w_last;

    assign w_mismatch = (bus.y != EXPECT[r_vec]);
    assign w_last     = (r_vec == 5'd31);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_vec   <= 5'd0;
            r_cnt   <= 4'd0;
            r_err   <= 6'd0;
            r_ff    <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_ff    <= w_ff_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_ff_nxt    = r_ff;

        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_state_nxt = RUN;
                    w_vec_nxt   = 5'd0;
                    w_cnt_nxt   = SETTLE_C;
                    w_err_nxt   = 6'd0;
                    w_ff_nxt    = 5'd0;
                end
            end

            RUN: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    // Sample edge: errors are booked here, before any exit to DONE.
                    if (w_mismatch) begin
                        if (r_err != 6'd32) begin
                            w_err_nxt = r_err + 6'd1;
                        end
                        if (r_err == 6'd0) begin
                            w_ff_nxt = r_vec;
                        end
                    end
`ifdef MUX_SWEEP_STOP_ON_FAIL_EN
                    if (w_mismatch || w_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_vec_nxt = r_vec + 5'd1;
                        w_cnt_nxt = SETTLE_C;
                    end
`else
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_vec_nxt = r_vec + 5'd1;
                        w_cnt_nxt = SETTLE_C;
                    end
`endif
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.a          = r_vec[4];
    assign bus.b          = r_vec[3];
    assign bus.c          = r_vec[2];
    assign bus.d          = r_vec[1];
    assign bus.e          = r_vec[0];
    assign bus.busy       = (r_state == RUN);
    assign bus.done       = (r_state == DONE);
    assign bus.pass       = (r_state == DONE) && (r_err == 6'd0);
    assign bus.err_count  = r_err;
    assign bus.first_fail = r_ff;

endmodule

// File: tb/tb_mux_func_sweeper.sv
// Directed bench for mux_func_sweeper: SETTLE=2 instance with injectable faults, SETTLE=0 instance clean.
// Expectations switch when MUX_SWEEP_STOP_ON_FAIL_EN is defined.
module tb_mux_func_sweeper;

    localparam logic [31:0] TRUTH = 32'hB31E114C;

    logic clk;
    logic rst_n;
    int   faultMode;
    int   vectors;
    int   miscompares;

    mux_func_sweeper_if bus0 ();
    mux_func_sweeper_if bus1 ();

    mux_func_sweeper #(.SETTLE(2), .EXPECT(32'hB31E114C)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.master)
    );

    mux_func_sweeper #(.SETTLE(0), .EXPECT(32'hB31E114C)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Function under test for dut0: golden table with optional faults (1 = stuck-at-0, 2 = invert at 17).
    always_comb begin
        logic [4:0] idx0;
        idx0    = {bus0.a, bus0.b, bus0.c, bus0.d, bus0.e};
        bus0.y  = TRUTH[idx0];
        if (faultMode == 1) begin
            bus0.y = 1'b0;
        end else if (faultMode == 2 && idx0 == 5'd17) begin
            bus0.y = ~TRUTH[idx0];
        end
    end

    always_comb begin
        logic [4:0] idx1;
        idx1   = {bus1.a, bus1.b, bus1.c, bus1.d, bus1.e};
        bus1.y = TRUTH[idx1];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Starts a sweep on the selected instance and counts busy cycles, checking the vector stepping.
    task automatic applyStimulus(input int sel, input bit holdStart, output int cycles, output bit seqOk);
        int  hold;
        logic [4:0] vec;
        hold = (sel == 0) ? 3 : 1;
        @(negedge clk);
        if (sel == 0) bus0.start = 1'b1; else bus1.start = 1'b1;
        @(negedge clk);
        if (!holdStart) begin
            bus0.start = 1'b0;
            bus1.start = 1'b0;
        end
        cycles = 0;
        seqOk  = 1'b1;
        while (((sel == 0) ? bus0.busy : bus1.busy) && cycles < 400) begin
            vec = (sel == 0) ? {bus0.a, bus0.b, bus0.c, bus0.d, bus0.e}
                             : {bus1.a, bus1.b, bus1.c, bus1.d, bus1.e};
            if (vec != 5'(cycles / hold)) seqOk = 1'b0;
            cycles++;
            @(negedge clk);
        end
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    initial begin
        int   cycles;
        bit   seqOk;
        int   waitCnt;

        vectors     = 0;
        miscompares = 0;
        faultMode   = 0;
        bus0.start  = 1'b0;
        bus1.start  = 1'b0;
        rst_n       = 1'b0;

        #12;
        checkOutput("rst_vec",   {27'd0, bus0.a, bus0.b, bus0.c, bus0.d, bus0.e}, 32'd0);
        checkOutput("rst_busy",  {31'd0, bus0.busy}, 32'd0);
        checkOutput("rst_done",  {31'd0, bus0.done}, 32'd0);
        checkOutput("rst_pass",  {31'd0, bus0.pass}, 32'd0);
        checkOutput("rst_err",   {26'd0, bus0.err_count}, 32'd0);
        checkOutput("rst_ff",    {27'd0, bus0.first_fail}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released");

        // Clean sweep, SETTLE=2
        applyStimulus(0, 1'b0, cycles, seqOk);
        checkOutput("clean_busy_cycles", 32'(cycles), 32'd96);
        checkOutput("clean_seq", {31'd0, seqOk}, 32'd1);
        checkOutput("clean_done", {31'd0, bus0.done}, 32'd1);
        checkOutput("clean_pass", {31'd0, bus0.pass}, 32'd1);
        checkOutput("clean_err", {26'd0, bus0.err_count}, 32'd0);
        checkOutput("clean_vec_hold", {27'd0, bus0.a, bus0.b, bus0.c, bus0.d, bus0.e}, 32'd31);
        repeat (3) @(negedge clk);
        checkOutput("done_holds", {31'd0, bus0.done}, 32'd1);

        // y stuck at 0
        faultMode = 1;
        applyStimulus(0, 1'b0, cycles, seqOk);
`ifdef MUX_SWEEP_STOP_ON_FAIL_EN
        checkOutput("stuck_busy_cycles", 32'(cycles), 32'd9);
        checkOutput("stuck_err", {26'd0, bus0.err_count}, 32'd1);
        checkOutput("stuck_vec", {27'd0, bus0.a, bus0.b, bus0.c, bus0.d, bus0.e}, 32'd2);
`else
        checkOutput("stuck_busy_cycles", 32'(cycles), 32'd96);
        checkOutput("stuck_err", {26'd0, bus0.err_count}, 32'd14);
        checkOutput("stuck_vec", {27'd0, bus0.a, bus0.b, bus0.c, bus0.d, bus0.e}, 32'd31);
`endif
        checkOutput("stuck_seq", {31'd0, seqOk}, 32'd1);
        checkOutput("stuck_done", {31'd0, bus0.done}, 32'd1);
        checkOutput("stuck_ff", {27'd0, bus0.first_fail}, 32'd2);
        checkOutput("stuck_pass", {31'd0, bus0.pass}, 32'd0);

        // y inverted only on vector 17
        faultMode = 2;
        applyStimulus(0, 1'b0, cycles, seqOk);
`ifdef MUX_SWEEP_STOP_ON_FAIL_EN
        checkOutput("inv17_busy_cycles", 32'(cycles), 32'd54);
        checkOutput("inv17_vec", {27'd0, bus0.a, bus0.b, bus0.c, bus0.d, bus0.e}, 32'd17);
`else
        checkOutput("inv17_busy_cycles", 32'(cycles), 32'd96);
        checkOutput("inv17_vec", {27'd0, bus0.a, bus0.b, bus0.c, bus0.d, bus0.e}, 32'd31);
`endif
        checkOutput("inv17_err", {26'd0, bus0.err_count}, 32'd1);
        checkOutput("inv17_ff", {27'd0, bus0.first_fail}, 32'd17);
        checkOutput("inv17_pass", {31'd0, bus0.pass}, 32'd0);

        // start held high through RUN must not restart; a fresh start clears the previous errors
        faultMode = 0;
        applyStimulus(0, 1'b1, cycles, seqOk);
        checkOutput("hold_busy_cycles", 32'(cycles), 32'd96);
        checkOutput("hold_seq", {31'd0, seqOk}, 32'd1);
        checkOutput("hold_pass", {31'd0, bus0.pass}, 32'd1);
        checkOutput("hold_ff_cleared", {27'd0, bus0.first_fail}, 32'd0);

        // Asynchronous reset mid-sweep at vector 10 while errors are accumulating
        faultMode = 1;
        @(negedge clk);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        waitCnt = 0;
        while ({bus0.a, bus0.b, bus0.c, bus0.d, bus0.e} != 5'd10 && waitCnt < 200) begin
            waitCnt++;
            @(negedge clk);
        end
        checkOutput("reach_vec10", 32'(waitCnt < 200), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_vec",  {27'd0, bus0.a, bus0.b, bus0.c, bus0.d, bus0.e}, 32'd0);
        checkOutput("midrst_busy", {31'd0, bus0.busy}, 32'd0);
        checkOutput("midrst_done", {31'd0, bus0.done}, 32'd0);
        checkOutput("midrst_err",  {26'd0, bus0.err_count}, 32'd0);
        checkOutput("midrst_ff",   {27'd0, bus0.first_fail}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        faultMode = 0;
        applyStimulus(0, 1'b0, cycles, seqOk);
        checkOutput("postrst_busy_cycles", 32'(cycles), 32'd96);
        checkOutput("postrst_seq", {31'd0, seqOk}, 32'd1);
        checkOutput("postrst_pass", {31'd0, bus0.pass}, 32'd1);

        // SETTLE=0 instance, correct function
        applyStimulus(1, 1'b0, cycles, seqOk);
        checkOutput("s0_busy_cycles", 32'(cycles), 32'd32);
        checkOutput("s0_seq", {31'd0, seqOk}, 32'd1);
        checkOutput("s0_done", {31'd0, bus1.done}, 32'd1);
        checkOutput("s0_pass", {31'd0, bus1.pass}, 32'd1);
        checkOutput("s0_err", {26'd0, bus1.err_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
